// File: rtl/fpnew_pkg.sv
// Shared types for the SIMD sequencer: per-lane FP status flags, sequencer
// states and the beat-count helper.
package fpnew_pkg;

  typedef struct packed {
    logic NV;
    logic DZ;
    logic OF;
    logic UF;
    logic NX;
  } status_t;

  typedef enum logic [1:0] {
    SEQ_IDLE,
    SEQ_ISSUE,
    SEQ_DRAIN,
    SEQ_DONE
  } seq_state_e;

  function automatic int unsigned num_beats(int unsigned width, int unsigned fp_width,
                                            int unsigned phys_lanes);
    return (width / fp_width) / phys_lanes;
  endfunction

endpackage

// File: rtl/fpnew_simd_sequencer.sv
// Time-multiplexes one packed SIMD FP operation over NumPhysLanes physical lanes
// and reassembles the in-order beat results into a single output transaction.
module fpnew_simd_sequencer import fpnew_pkg::*; #(
  parameter int unsigned Width        = 64,
  parameter int unsigned FpWidth      = 16,
  parameter int unsigned NumPhysLanes = 1,
  parameter int unsigned NumOperands  = 3,
  parameter type         TagType      = logic
) (
  input  logic                                    clk_i,
  input  logic                                    rst_ni,
  input  logic [NumOperands*Width-1:0]            operands_i,
  input  logic                                    vectorial_op_i,
  input  logic [Width/FpWidth-1:0]                simd_mask_i,
  input  TagType                                  tag_i,
  input  logic                                    in_valid_i,
  output logic                                    in_ready_o,
  input  logic                                    flush_i,
  output logic [NumPhysLanes*NumOperands*FpWidth-1:0] unit_operands_o,
  output logic [NumPhysLanes-1:0]                 unit_mask_o,
  output logic                                    unit_valid_o,
  input  logic                                    unit_ready_i,
  input  logic [NumPhysLanes*FpWidth-1:0]         unit_result_i,
  input  logic [NumPhysLanes*5-1:0]               unit_status_i,
  input  logic                                    unit_valid_i,
  output logic                                    unit_ready_o,
  output logic [Width-1:0]                        result_o,
  output status_t                                 status_o,
  output TagType                                  tag_o,
  output logic                                    out_valid_o,
  input  logic                                    out_ready_i,
  output logic                                    busy_o
);

  localparam int unsigned NUM_LANES = Width / FpWidth;
  localparam int unsigned NUM_BEATS = num_beats(Width, FpWidth, NumPhysLanes);
  localparam int unsigned CNT_W     = $clog2(NUM_BEATS + 1);

  if ((Width / FpWidth) % NumPhysLanes != 0) begin : g_bad_lane_cfg
    $error("NumPhysLanes must divide Width/FpWidth");
  end

  seq_state_e                   state_q, state_d;
  logic [CNT_W-1:0]             issue_cnt_q, issue_cnt_d;
  logic [CNT_W-1:0]             collect_cnt_q, collect_cnt_d;
  logic [CNT_W-1:0]             beats_q, beats_d;
  logic [NumOperands*Width-1:0] ops_q, ops_d;
  logic [NUM_LANES-1:0]         mask_q, mask_d;
  TagType                       tag_q, tag_d;
  logic [Width-1:0]             result_q, result_d;
  status_t                      status_q, status_d;

  logic issue_fire, collect_legal, collect_fire;

  always_comb begin
    state_d       = state_q;
    issue_cnt_d   = issue_cnt_q;
    collect_cnt_d = collect_cnt_q;
    beats_d       = beats_q;
    ops_d         = ops_q;
    mask_d        = mask_q;
    tag_d         = tag_q;
    result_d      = result_q;
    status_d      = status_q;
    in_ready_o    = 1'b0;
    unit_valid_o  = 1'b0;
    unit_ready_o  = 1'b0;
    out_valid_o   = 1'b0;

    unique case (state_q)
      SEQ_IDLE: begin
        in_ready_o = ~flush_i;
        if (in_valid_i && !flush_i) begin
          ops_d         = operands_i;
          // Scalar ops only honour lane 0 of the mask.
          mask_d        = vectorial_op_i ? simd_mask_i : NUM_LANES'(simd_mask_i[0]);
          tag_d         = tag_i;
          beats_d       = vectorial_op_i ? CNT_W'(NUM_BEATS) : CNT_W'(1);
          issue_cnt_d   = '0;
          collect_cnt_d = '0;
          result_d      = '1;
          status_d      = '0;
          state_d       = SEQ_ISSUE;
        end
      end
      SEQ_ISSUE: begin
        unit_valid_o = 1'b1;
        unit_ready_o = 1'b1;
      end
      SEQ_DRAIN: unit_ready_o = 1'b1;
      SEQ_DONE:  out_valid_o  = 1'b1;
      default:   state_d      = SEQ_IDLE;
    endcase

    issue_fire    = unit_valid_o & unit_ready_i;
    // A zero-latency unit returns its result in the same cycle the beat is issued.
    collect_legal = unit_ready_o && (collect_cnt_q < beats_q)
                    && ((collect_cnt_q < issue_cnt_q) || issue_fire);
    collect_fire  = unit_valid_i & ~flush_i & collect_legal;

    if (issue_fire) issue_cnt_d = issue_cnt_q + CNT_W'(1);

    if (collect_fire) begin
      for (int unsigned p = 0; p < NumPhysLanes; p++) begin
        result_d[(32'(collect_cnt_q) * NumPhysLanes + p) * FpWidth +: FpWidth] =
            unit_result_i[p*FpWidth +: FpWidth];
        status_d = status_t'(status_d | (unit_status_i[p*5 +: 5]
                   & {5{mask_q[32'(collect_cnt_q) * NumPhysLanes + p]}}));
      end
      collect_cnt_d = collect_cnt_q + CNT_W'(1);
    end

    if (state_q == SEQ_ISSUE && issue_fire && issue_cnt_d == beats_q)
      state_d = (collect_cnt_d == beats_q) ? SEQ_DONE : SEQ_DRAIN;
    if (state_q == SEQ_DRAIN && collect_cnt_d == beats_q) state_d = SEQ_DONE;
    if (state_q == SEQ_DONE && out_ready_i) state_d = SEQ_IDLE;

    if (flush_i) begin
      state_d       = SEQ_IDLE;
      issue_cnt_d   = '0;
      collect_cnt_d = '0;
    end
  end

  always_comb begin
    unit_operands_o = '0;
    unit_mask_o     = '0;
    if (state_q == SEQ_ISSUE) begin
      for (int unsigned o = 0; o < NumOperands; o++) begin
        for (int unsigned p = 0; p < NumPhysLanes; p++) begin
          unit_operands_o[(o*NumPhysLanes + p) * FpWidth +: FpWidth] =
              ops_q[o*Width + (32'(issue_cnt_q) * NumPhysLanes + p) * FpWidth +: FpWidth];
        end
      end
      for (int unsigned p = 0; p < NumPhysLanes; p++)
        unit_mask_o[p] = mask_q[32'(issue_cnt_q) * NumPhysLanes + p];
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q       <= SEQ_IDLE;
      issue_cnt_q   <= '0;
      collect_cnt_q <= '0;
      beats_q       <= '0;
      ops_q         <= '0;
      mask_q        <= '0;
      tag_q         <= '0;
      result_q      <= '0;
      status_q      <= '0;
    end else begin
      state_q       <= state_d;
      issue_cnt_q   <= issue_cnt_d;
      collect_cnt_q <= collect_cnt_d;
      beats_q       <= beats_d;
      ops_q         <= ops_d;
      mask_q        <= mask_d;
      tag_q         <= tag_d;
      result_q      <= result_d;
      status_q      <= status_d;
    end
  end

  assign result_o = result_q;
  assign status_o = status_q;
  assign tag_o    = tag_q;
  assign busy_o   = (state_q != SEQ_IDLE);

  a_collect_legal: assert property (@(posedge clk_i) disable iff (!rst_ni)
      (unit_valid_i && !flush_i) |-> collect_legal);

  a_issue_stable: assert property (@(posedge clk_i) disable iff (!rst_ni)
      (unit_valid_o && !unit_ready_i && !flush_i)
      |=> (unit_valid_o && $stable(unit_operands_o) && $stable(unit_mask_o)));

  a_out_stable: assert property (@(posedge clk_i) disable iff (!rst_ni)
      (out_valid_o && !out_ready_i && !flush_i)
      |=> (out_valid_o && $stable(result_o) && $stable(status_o) && $stable(tag_o)));

endmodule
